// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_stage
// Purpose  : Registered 16-bit instruction decode with a 2-entry skid buffer
//            and a sticky halt on an accepted HALT instruction.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        resume,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [2:0]  out_rd,
    output logic [2:0]  out_rs1,
    output logic [2:0]  out_rs2,
    output logic [2:0]  out_constant,
    output logic        out_immediate_flag,
    output logic        out_halt,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] constant;
        logic       immediate_flag;
        logic       halt;
    } rec_t;

    localparam logic [3:0] c_op_halt = 4'hF;

    state_t r_state;
    state_t w_state_next;
    rec_t   r_mem [2];
    rec_t   w_dec;
    rec_t   w_head;
    logic   r_rd_ptr;
    logic   r_wr_ptr;
    logic   r_halted;
    logic   w_push;
    logic   w_pop;

    // rst_n gates in_ready so fetch sees "not ready" for the whole reset window.
    assign in_ready  = rst_n & (r_state != S_FULL) & ~r_halted & ~flush;
    assign out_valid = (r_state != S_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign halted    = r_halted;

    always_comb begin
        w_dec                = '0;
        w_dec.opcode         = in_instr[15:12];
        w_dec.rd             = in_instr[11:9];
        w_dec.rs1            = in_instr[8:6];
        w_dec.rs2            = in_instr[5:3];
        w_dec.constant       = in_instr[2:0];
        w_dec.immediate_flag = (in_instr[15:12] >= 4'h8) && (in_instr[15:12] != c_op_halt);
        w_dec.halt           = (in_instr[15:12] == c_op_halt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) w_state_next = S_ONE;
                S_ONE: begin
                    if (w_push && !w_pop)      w_state_next = S_FULL;
                    else if (w_pop && !w_push) w_state_next = S_EMPTY;
                end
                S_FULL:  if (w_pop) w_state_next = S_ONE;
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dec;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // A HALT accepted in the same cycle as resume keeps the stage halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (flush) begin
            r_halted <= 1'b0;
        end else if (w_push && w_dec.halt) begin
            r_halted <= 1'b1;
        end else if (resume) begin
            r_halted <= 1'b0;
        end
    end

    assign w_head             = r_mem[r_rd_ptr];
    assign out_opcode         = w_head.opcode;
    assign out_rd             = w_head.rd;
    assign out_rs1            = w_head.rs1;
    assign out_rs2            = w_head.rs2;
    assign out_constant       = w_head.constant;
    assign out_immediate_flag = w_head.immediate_flag;
    assign out_halt           = w_head.halt;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decode_stage
// Purpose  : Queue-based reference model plus directed and random stimulus
//            for instr_decode_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        resume = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd;
    logic [2:0]  out_rs1;
    logic [2:0]  out_rs2;
    logic [2:0]  out_constant;
    logic        out_immediate_flag;
    logic        out_halt;
    logic        halted;

    int tests = 0;
    int fails = 0;

    instr_decode_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .resume             (resume),
        .in_valid           (in_valid),
        .in_instr           (in_instr),
        .in_ready           (in_ready),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_opcode         (out_opcode),
        .out_rd             (out_rd),
        .out_rs1            (out_rs1),
        .out_rs2            (out_rs2),
        .out_constant       (out_constant),
        .out_immediate_flag (out_immediate_flag),
        .out_halt           (out_halt),
        .halted             (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of raw instruction words plus a halt flag.
    logic [15:0] m_q[$];
    bit          m_halted = 1'b0;

    function automatic bit model_ready();
        return rst_n && (m_q.size() < 2) && !m_halted && !flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_halted = 1'b0;
        end else begin
            bit push;
            bit pop;
            push = in_valid && model_ready();
            pop  = (m_q.size() > 0) && out_ready && !flush;
            if (flush) begin
                m_q.delete();
                m_halted = 1'b0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(in_instr);
                if (push && in_instr[15:12] == 4'hF) m_halted = 1'b1;
                else if (resume) m_halted = 1'b0;
            end
        end
    end

    // Every cycle, just before the rising edge, compare the DUT with the model.
    always @(negedge clk) begin
        #3;
        chk("in_ready", in_ready, model_ready());
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("halted", halted, m_halted);
        if (m_q.size() != 0 && out_valid) begin
            logic [15:0] h;
            int op;
            h  = m_q[0];
            op = h[15:12];
            chk("opcode", out_opcode, op);
            chk("rd", out_rd, h[11:9]);
            chk("rs1", out_rs1, h[8:6]);
            chk("rs2", out_rs2, h[5:3]);
            chk("constant", out_constant, h[2:0]);
            chk("imm_flag", out_immediate_flag, (op >= 8 && op <= 14));
            chk("halt_flag", out_halt, op == 15);
        end
    end

    task automatic drive(input logic v, input logic [15:0] w, input logic ordy,
                         input logic fl, input logic res);
        @(negedge clk);
        #2;
        in_valid  = v;
        in_instr  = w;
        out_ready = ordy;
        flush     = fl;
        resume    = res;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fields", {out_opcode, out_rd, out_rs1, out_rs2, out_constant,
                           out_immediate_flag, out_halt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Single push of 8A5B
        drive(1, 16'h8A5B, 1, 0, 0);
        drive(0, 16'h0, 1, 0, 0);
        #2;
        chk("single_valid", out_valid, 1);
        chk("single_fields", {out_opcode, out_rd, out_rs1, out_rs2, out_constant,
                              out_immediate_flag}, {4'h8, 3'd5, 3'd1, 3'd3, 3'd3, 1'b1});
        drive(0, 16'h0, 1, 0, 0);
        #2;
        chk("single_drained", out_valid, 0);

        // Back-pressure
        drive(1, 16'h1240, 0, 0, 0);
        drive(1, 16'h2481, 0, 0, 0);
        drive(1, 16'h3000, 0, 0, 0);
        #2;
        chk("bp_full_ready", in_ready, 0);
        chk("bp_head", out_opcode, 4'h1);
        drive(1, 16'h3000, 1, 0, 0);
        drive(1, 16'h3000, 1, 0, 0);
        #2;
        chk("bp_second", out_opcode, 4'h2);
        chk("bp_ready_back", in_ready, 1);
        drive(0, 16'h0, 1, 0, 0);
        #2;
        chk("bp_third", out_opcode, 4'h3);
        drive(0, 16'h0, 1, 0, 0);

        // Streaming at occupancy one
        for (int i = 0; i < 8; i++) drive(1, 16'h1000 + 16'(i * 16'h0111), 1, 0, 0);
        drive(0, 16'h0, 1, 0, 0);

        // HALT then resume
        drive(1, 16'hF000, 1, 0, 0);
        drive(1, 16'h1111, 1, 0, 0);
        #2;
        chk("halt_flag_out", out_halt, 1);
        chk("halt_imm", out_immediate_flag, 0);
        chk("halt_halted", halted, 1);
        chk("halt_ready", in_ready, 0);
        drive(1, 16'h1111, 1, 0, 0);
        #2;
        chk("halt_no_accept", out_valid, 0);
        drive(1, 16'h1111, 1, 0, 1);
        drive(1, 16'h1111, 1, 0, 0);
        #2;
        chk("resume_cleared", halted, 0);
        drive(0, 16'h0, 1, 0, 0);
        #2;
        chk("resume_accept", out_opcode, 4'h1);

        // Resume coincident with HALT push
        drive(1, 16'hF222, 1, 0, 1);
        drive(0, 16'h0, 1, 0, 0);
        #2;
        chk("halt_wins", halted, 1);
        drive(0, 16'h0, 1, 0, 1);
        drive(0, 16'h0, 1, 0, 0);

        // Flush while full and halted
        drive(1, 16'h1000, 0, 0, 0);
        drive(1, 16'hF000, 0, 0, 0);
        drive(1, 16'h5555, 1, 1, 0);
        drive(0, 16'h0, 1, 0, 0);
        #2;
        chk("flush_valid", out_valid, 0);
        chk("flush_halted", halted, 0);
        chk("flush_ready", in_ready, 1);

        // Asynchronous reset while full
        drive(1, 16'h2222, 0, 0, 0);
        drive(1, 16'h3333, 0, 0, 0);
        drive(0, 16'h0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 0);
        drive(0, 16'h0, 1, 0, 0);
        #1;
        rst_n = 1'b1;
        drive(0, 16'h0, 1, 0, 0);
        #2;
        chk("arst_rel_ready", in_ready, 1);
        chk("arst_no_stale", out_valid, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 5) == 0));
        end
        drive(0, 16'h0, 1, 0, 0);
        drive(0, 16'h0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
